// File: rtl/fifo_out_stream_reader_if.sv
// Bus bundle for fifo_out_stream_reader.
//   fifo_*  : Avalon-MM read side of the on-chip FIFO "out" slave
//             (read / readdata / waitrequest, read latency 0).
//   out_*   : valid/ready element stream toward the convolution loader.
// master = reader side (drives fifo_read and out_valid/out_data/out_last),
// slave  = FIFO + downstream side.
interface fifo_out_stream_reader_if #(
  parameter int DATA_W = 64,
  parameter int LANE_W = 16
);
  logic              fifo_read;
  logic [DATA_W-1:0] fifo_readdata;
  logic              fifo_waitrequest;
  logic              out_valid;
  logic [LANE_W-1:0] out_data;
  logic              out_last;
  logic              out_ready;

  modport master (
    output fifo_read,
    input  fifo_readdata,
    input  fifo_waitrequest,
    output out_valid,
    output out_data,
    output out_last,
    input  out_ready
  );

  modport slave (
    input  fifo_read,
    output fifo_readdata,
    output fifo_waitrequest,
    input  out_valid,
    input  out_data,
    input  out_last,
    output out_ready
  );
endinterface

// File: rtl/fifo_out_stream_reader.sv
// fifo_out_stream_reader
// Drains `len` 64-bit words from the HPS-to-FPGA FIFO output port and
// emits them as 16-bit elements, lane 0 ([15:0]) first, lane 3 last.
// Ports:
//   clk_clk, reset_reset_n : clock, async active-low reset
//   start, len             : command pulse (sampled in IDLE) and word count
//   busy, done             : transfer in progress / one-cycle completion
//   bus (master)           : FIFO read port + output stream
module fifo_out_stream_reader #(
  parameter int DATA_W = 64,
  parameter int LANE_W = 16,
  parameter int LEN_W  = 20
) (
  input  logic                     clk_clk,
  input  logic                     reset_reset_n,
  input  logic                     start,
  input  logic [LEN_W-1:0]         len,
  output logic                     busy,
  output logic                     done,
  fifo_out_stream_reader_if.master bus
);
  localparam int NUM_LANES = DATA_W / LANE_W;
  localparam int LANE_IW   = $clog2(NUM_LANES);
  localparam logic [LANE_IW-1:0] LAST_LANE = LANE_IW'(NUM_LANES - 1);

  typedef enum logic [1:0] {S_IDLE, S_READ, S_DONE} state_t;

  state_t                           state_q, state_d;
  logic [LEN_W-1:0]                 words_left;
  logic [NUM_LANES-1:0][LANE_W-1:0] buf_q;
  logic                             buf_valid;
  logic [LANE_IW-1:0]               lane;
  logic                             hs, rd_acc, at_last_lane;

  assign at_last_lane = (lane == LAST_LANE);
  assign hs           = buf_valid && bus.out_ready;

  // Refill when empty, or in the same cycle the last lane leaves, so words
  // stream back to back. Once raised, the condition cannot drop before the
  // accept: an empty buffer stays empty, and a held lane-3 handshake implies
  // out_ready was high, which the read path does not depend on changing.
  assign bus.fifo_read = (state_q == S_READ) && (words_left != '0) &&
                         (!buf_valid || (at_last_lane && hs));
  assign rd_acc        = bus.fifo_read && !bus.fifo_waitrequest;

  assign bus.out_valid = buf_valid;
  assign bus.out_data  = buf_valid ? buf_q[lane] : '0;
  // words_left has already counted the buffered word, so zero here means
  // the buffer holds the final word of the transfer.
  assign bus.out_last  = buf_valid && at_last_lane && (words_left == '0);

  assign busy = (state_q == S_READ);
  assign done = (state_q == S_DONE);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: if (start) state_d = (len != '0) ? S_READ : S_DONE;
      S_READ: if (hs && bus.out_last) state_d = S_DONE;
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) state_q <= S_IDLE;
    else                state_q <= state_d;
  end

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      words_left <= '0;
      buf_q      <= '0;
      buf_valid  <= 1'b0;
      lane       <= '0;
    end else begin
      if (state_q == S_IDLE && start)
        words_left <= len;
      else if (rd_acc)
        words_left <= words_left - LEN_W'(1);

      if (rd_acc) begin
        buf_q     <= bus.fifo_readdata;
        buf_valid <= 1'b1;
        lane      <= '0;
      end else if (hs) begin
        lane <= lane + LANE_IW'(1);
        if (at_last_lane) buf_valid <= 1'b0;
      end
    end
  end
endmodule

// File: doc/fifo_out_stream_reader.md
# fifo_out_stream_reader

Avalon-MM read master that drains the 64-bit output port of the HPS-to-FPGA on-chip FIFO and turns it into a 16-bit valid/ready stream for the VGG16 convolution datapath. It sits in the FPGA fabric between the FIFO's `out` slave (read/readdata/waitrequest) and the accelerator's weight/activation loader. Each 64-bit word carries four 16-bit fixed-point values. A transfer is started by a length command and ends with a `done` pulse.

## Interface
Parameters:
- `DATA_W`, 64: FIFO readdata width. Fixed at 4×`LANE_W`.
- `LANE_W`, 16: output element width.
- `LEN_W`, 20: width of the word-count command.

Ports:
- `clk_clk`  in  1  single clock for all logic.
- `reset_reset_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  one-cycle command pulse. Sampled only in IDLE.
- `len`  in  LEN_W  number of 64-bit words to read. Latched on `start`.
- `busy`  out  1  high from the cycle after an accepted `start` until the `done` cycle.
- `done`  out  1  one-cycle pulse when the transfer completes.
- `fifo_read`  out  1  Avalon read request.
- `fifo_readdata`  in  DATA_W  FIFO word.
- `fifo_waitrequest`  in  1  Avalon wait request.
- `out_valid`  out  1  stream valid.
- `out_data`  out  LANE_W  stream element.
- `out_last`  out  1  marks the final element of the transfer.
- `out_ready`  in  1  downstream ready.

## Operation
- The FSM has three states: IDLE, READ, DONE.
  - IDLE → READ on `start` when `len` != 0. This loads `words_left = len`.
  - IDLE → DONE on `start` when `len` == 0.
  - READ → DONE on the handshake of the lane that carries `out_last`.
  - DONE → IDLE unconditionally after one cycle. `done` = 1 only in DONE.
- `start` is ignored while `busy` or in DONE.
- Word buffer: a 64-bit register, a `buf_valid` flag, and a 2-bit lane index.
  - Lane 0 = `fifo_readdata[15:0]` is emitted first. Lane 3 = `[63:48]` is emitted last.
- Read request, combinational: `fifo_read` = READ && `words_left` != 0 && (!`buf_valid` || (lane == 3 && `out_valid` && `out_ready`)).
  - This allows back-to-back words with no bubble.
- Read accept: the cycle with `fifo_read` && !`fifo_waitrequest`. Readdata is valid in that same cycle (read latency 0).
  - On accept: capture the word, set `buf_valid`, reset lane to 0, and decrement `words_left`.
  - Once `fifo_read` is asserted it stays high with no change until it is accepted. This holds because the buffer condition cannot deassert while `out_valid` is held.
- Stream side:
  - `out_valid` = `buf_valid`.
  - `out_data` = the selected lane.
  - `out_last` = `buf_valid` && lane == 3 && `words_left` == 0.
  - Handshake on `out_valid` && `out_ready`: the lane advances. After lane 3, `buf_valid` clears unless a new word is accepted in the same cycle.
- `out_data` and `out_last` stay stable while `out_valid` && !`out_ready`.
- Counter width: `words_left` is LEN_W bits and only decrements when it is non-zero. It never wraps.
- Reset, including mid-transfer: all state goes to IDLE and the buffer empties.
  - Any read in flight is abandoned. Recovering the FIFO is software's job.

## Timing
- Reset values:
  - `busy` = 0, `done` = 0, `fifo_read` = 0.
  - `out_valid` = 0, `out_last` = 0, `out_data` = 0.
- `start` at cycle T with `len` > 0: `busy` = 1 and `fifo_read` = 1 at T+1.
- Read accepted at cycle A: the first element is valid at A+1.
- Sustained throughput is 1 element/cycle, with 1 read per 4 cycles, when waitrequest = 0 and ready = 1.
- `len` = N with no stalls: the final element is at T+1+4N. `done` and `busy` fall together at T+2+4N.
- `len` = 0: `done` at T+1, no reads, `busy` stays 0.
- Waitrequest and ready stalls add cycle-for-cycle delay. Elements are never dropped or duplicated.

## Test plan
- **Basic transfer.** `len`=2, FIFO words 0x0004_0003_0002_0001 and 0x0008_0007_0006_0005, waitrequest=0, ready=1.
  - Required: `out_data` = 1..8 on consecutive cycles, `out_last` only on 8, exactly 2 read accepts, `done` one cycle after element 8.
- **Waitrequest stall.** First read sees waitrequest=1 for 5 cycles.
  - Required: `fifo_read` held high for 6 cycles, no `out_valid`, then elements 1..4 follow normally.
- **Backpressure.** `out_ready` toggled 1,0,0,1 repeating, `len`=3.
  - Required: `out_data`/`out_last` stable while stalled, no read issued while the buffer holds lanes 0–2, all 12 elements in order.
- **Zero length.** `len`=0.
  - Required: `done` at T+1, `fifo_read` never asserted, `out_valid` stays 0.
- **Command and reset robustness.**
  - `start` with `len`=5 pulsed while `busy` → ignored; the original `len`=2 transfer emits exactly 8 elements.
  - Async reset asserted mid-word → all outputs 0 immediately.
  - After release, a new `start` with `len`=1 reads 1 word and emits 4 elements.
